branch_resolve_unit: RTL

Execute-stage branch resolver for the RISCV32 core. It receives the `Branch` strobe and `funct3` that the front end already qualifies for B-type instructions, compares the operands, and decides taken or not-taken. On a redirect it computes the target PC, holds a fetch-redirect handshake until fetch accepts, then asserts a bounded pipeline flush. It sits between the ID/EX pipeline register and the fetch/hazard units.

---
 rtl/riscv_pkg.sv | 24 ++
 rtl/branch_resolve_unit_if.sv | 47 ++++
 rtl/branch_compare.sv | 38 +++
 rtl/branch_resolve_unit.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V execute-stage definitions: B-type funct3 encodings,
// branch resolver FSM states and the sequential PC increment.
package riscv_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam int unsigned PC_INC = 4;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REDIRECT = 2'd1,
        ST_FLUSH    = 2'd2
    } br_state_t;

    function automatic logic is_word_aligned(input logic [1:0] lsb);
        return lsb == 2'b00;
    endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// ID/EX-to-resolver and resolver-to-fetch/hazard signal bundle.
// Mispredict_Count exists only when BRANCH_PREDICT_EN is defined.
interface branch_resolve_unit_if #(parameter int XLEN = 32);

    logic            Branch;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic            stall;
    logic            Redirect_Ready;
    logic            Pred_Taken;

    logic            Branch_Taken;
    logic            Redirect_Valid;
    logic [XLEN-1:0] Redirect_PC;
    logic            Flush;
    logic            Illegal_Branch;
    logic            Misalign;
    logic [31:0]     Branch_Count;
    logic [31:0]     Taken_Count;
`ifdef BRANCH_PREDICT_EN
    logic [31:0]     Mispredict_Count;
`endif

    modport master (
        output Branch, funct3, rs1_data, rs2_data, pc, imm, stall,
               Redirect_Ready, Pred_Taken,
        input  Branch_Taken, Redirect_Valid, Redirect_PC, Flush,
               Illegal_Branch, Misalign, Branch_Count, Taken_Count
`ifdef BRANCH_PREDICT_EN
        , input Mispredict_Count
`endif
    );

    modport slave (
        input  Branch, funct3, rs1_data, rs2_data, pc, imm, stall,
               Redirect_Ready, Pred_Taken,
        output Branch_Taken, Redirect_Valid, Redirect_PC, Flush,
               Illegal_Branch, Misalign, Branch_Count, Taken_Count
`ifdef BRANCH_PREDICT_EN
        , output Mispredict_Count
`endif
    );

endinterface

// File: rtl/branch_compare.sv
// Combinational B-type condition decode and operand compare.
// Reserved encodings 010/011 resolve not-taken and flag illegal.
module branch_compare
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    output logic            o_taken,
    output logic            o_illegal
);

    logic w_eq;
    logic w_lt_s;
    logic w_lt_u;

    assign w_eq   = (i_rs1 == i_rs2);
    assign w_lt_s = ($signed(i_rs1) < $signed(i_rs2));
    assign w_lt_u = (i_rs1 < i_rs2);

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs; no latch.
        o_taken   = 1'b0;
        o_illegal = 1'b0;
        case (i_funct3)
            F3_BEQ:  o_taken = w_eq;
            F3_BNE:  o_taken = !w_eq;
            F3_BLT:  o_taken = w_lt_s;
            F3_BGE:  o_taken = !w_lt_s;
            F3_BLTU: o_taken = w_lt_u;
            F3_BGEU: o_taken = !w_lt_u;
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolver: compare, redirect handshake, bounded flush.
// BRANCH_PREDICT_EN: redirect only on mispredict and count mispredicts.
module branch_resolve_unit
    import riscv_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input logic                  clk,
    input logic                  rst,
    branch_resolve_unit_if.slave brif
);

    br_state_t       r_state;
    br_state_t       w_state_next;
    logic [3:0]      r_flush_cnt;
    logic [3:0]      w_flush_cnt_next;

    logic            r_branch_taken;
    logic            r_illegal;
    logic            r_misalign;
    logic [XLEN-1:0] r_redirect_pc;
    logic [31:0]     r_branch_count;
    logic [31:0]     r_taken_count;

    logic            w_taken;
    logic            w_illegal;
    logic            w_accept;
    logic            w_aligned;
    logic            w_misaligned_taken;
    logic            w_need_redirect;
    logic [XLEN-1:0] w_target;
    logic [XLEN-1:0] w_redirect_target;
    logic            w_redirect_valid;
    logic            w_flush;

    branch_compare #(.XLEN(XLEN)) u_compare (
        .i_funct3  (brif.funct3),
        .i_rs1     (brif.rs1_data),
        .i_rs2     (brif.rs2_data),
        .o_taken   (w_taken),
        .o_illegal (w_illegal)
    );

    // Wrong-path branches arriving in REDIRECT/FLUSH are never accepted.
    assign w_accept           = (r_state == ST_IDLE) && brif.Branch && !brif.stall;
    assign w_target           = brif.pc + brif.imm;
    assign w_aligned          = is_word_aligned(w_target[1:0]);
    assign w_misaligned_taken = w_taken && !w_aligned;

`ifdef BRANCH_PREDICT_EN
    logic [XLEN-1:0] w_fallthru;
    logic [31:0]     r_mispredict_count;

    assign w_fallthru        = brif.pc + XLEN'(PC_INC);
    assign w_need_redirect   = !w_misaligned_taken && (w_taken != brif.Pred_Taken);
    assign w_redirect_target = w_taken ? w_target : w_fallthru;
`else
    logic w_unused_pred;

    assign w_unused_pred     = brif.Pred_Taken;
    assign w_need_redirect   = w_taken && w_aligned;
    assign w_redirect_target = w_target;
`endif

    always_ff @(posedge clk) begin
        // NOTE: registered state always uses non-blocking assignment.
        if (rst) begin
            r_state     <= ST_IDLE;
            r_flush_cnt <= '0;
        end else begin
            r_state     <= w_state_next;
            r_flush_cnt <= w_flush_cnt_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_flush_cnt_next = r_flush_cnt;
        w_redirect_valid = 1'b0;
        w_flush          = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && w_need_redirect) w_state_next = ST_REDIRECT;
            end
            ST_REDIRECT: begin
                w_redirect_valid = 1'b1;
                if (brif.Redirect_Ready) begin
                    w_state_next     = ST_FLUSH;
                    w_flush_cnt_next = 4'(FLUSH_CYCLES);
                end
            end
            ST_FLUSH: begin
                w_flush = 1'b1;
                if (r_flush_cnt <= 4'd1) w_state_next = ST_IDLE;
                else                     w_flush_cnt_next = r_flush_cnt - 4'd1;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_branch_taken <= 1'b0;
            r_illegal      <= 1'b0;
            r_misalign     <= 1'b0;
            r_redirect_pc  <= '0;
            r_branch_count <= '0;
            r_taken_count  <= '0;
        end else begin
            r_illegal  <= w_accept && w_illegal;
            r_misalign <= w_accept && w_misaligned_taken;
            if (w_accept) begin
                r_branch_taken <= w_taken;
                r_branch_count <= r_branch_count + 32'd1;
                if (w_taken && w_aligned) r_taken_count <= r_taken_count + 32'd1;
                if (w_need_redirect)      r_redirect_pc <= w_redirect_target;
            end
        end
    end

`ifdef BRANCH_PREDICT_EN
    always_ff @(posedge clk) begin
        if (rst)                             r_mispredict_count <= '0;
        else if (w_accept && w_need_redirect) r_mispredict_count <= r_mispredict_count + 32'd1;
    end

    assign brif.Mispredict_Count = r_mispredict_count;
`endif

    assign brif.Branch_Taken   = r_branch_taken;
    assign brif.Redirect_Valid = w_redirect_valid;
    assign brif.Redirect_PC    = r_redirect_pc;
    assign brif.Flush          = w_flush;
    assign brif.Illegal_Branch = r_illegal;
    assign brif.Misalign       = r_misalign;
    assign brif.Branch_Count   = r_branch_count;
    assign brif.Taken_Count    = r_taken_count;

endmodule
